// File: rtl/mem_access_aligner_if.sv
// Request/response bundle between the core and the memory access aligner.
// The master drives requests and out_ready; the slave is the aligner itself.
interface mem_access_aligner_if #(
  parameter int DATA_W = 32
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  logic              in_valid;
  logic              in_ready;
  logic              in_is_store;
  logic [1:0]        in_size;
  logic              in_unsigned;
  logic [OFF_W-1:0]  in_offset;
  logic [DATA_W-1:0] in_wdata;
  logic [DATA_W-1:0] in_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [NB-1:0]     out_byte_en;
  logic              out_misaligned;

  modport master (
    output in_valid, in_is_store, in_size, in_unsigned, in_offset,
           in_wdata, in_rdata, out_ready,
    input  in_ready, out_valid, out_data, out_byte_en, out_misaligned
  );

  modport slave (
    input  in_valid, in_is_store, in_size, in_unsigned, in_offset,
           in_wdata, in_rdata, out_ready,
    output in_ready, out_valid, out_data, out_byte_en, out_misaligned
  );
endinterface

// File: rtl/mem_access_aligner.sv
// Load extension / store lane positioning between data memory and write-back,
// with misalignment detection, a saturating error counter and a one-deep output register.
module mem_access_aligner #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_access_aligner_if.slave bus,
  input  logic                err_clr,
  output logic [CNT_W-1:0]    err_count
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int SHW   = OFF_W + 3;

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [NB-1:0]     r_byte_en;
  logic              r_misaligned;
  logic [CNT_W-1:0]  r_err_count;

  logic              w_accept;
  logic [3:0]        w_sz;
  logic [SHW-1:0]    w_shamt;
  logic              w_misaligned;
  logic              w_sign;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_store_lanes;
  logic [DATA_W-1:0] w_store;
  logic [DATA_W-1:0] w_result;
  logic [NB-1:0]     w_byte_en;

  assign bus.in_ready = !r_valid || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;

  // Access size in bytes; a size wider than the bus or an offset not a multiple of it is illegal.
  assign w_sz         = 4'd1 << bus.in_size;
  assign w_shamt      = {bus.in_offset, 3'b000};
  assign w_misaligned = (w_sz > 4'(NB)) ||
                        ((4'(bus.in_offset) & (w_sz - 4'd1)) != 4'd0);
  assign w_shifted    = bus.in_rdata >> w_shamt;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    w_sign        = 1'b0;
    w_load        = '0;
    w_store_lanes = '0;
    w_byte_en     = '0;

    case (bus.in_size)
      2'b00:   w_sign = w_shifted[7];
      2'b01:   w_sign = w_shifted[15];
      2'b10:   w_sign = w_shifted[31];
      default: w_sign = w_shifted[DATA_W-1];
    endcase
    w_sign = w_sign && !bus.in_unsigned;

    // Lanes below the access size carry data; the rest take the extension (load) or zero (store).
    for (int i = 0; i < NB; i++) begin
      w_load[8*i +: 8]        = (4'(i) < w_sz) ? w_shifted[8*i +: 8] : {8{w_sign}};
      w_store_lanes[8*i +: 8] = (4'(i) < w_sz) ? bus.in_wdata[8*i +: 8] : 8'h00;
      w_byte_en[i]            = (4'(i) >= 4'(bus.in_offset)) &&
                                (4'(i) < (4'(bus.in_offset) + w_sz));
    end

    w_store  = w_store_lanes << w_shamt;
    w_result = bus.in_is_store ? w_store : w_load;

    if (w_misaligned) begin
      w_result  = '0;
      w_byte_en = '0;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  // NOTE: the result registers are reset too, since their value is visible on the outputs after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_byte_en    <= '0;
      r_misaligned <= 1'b0;
    end else if (w_accept) begin
      r_valid      <= 1'b1;
      r_data       <= w_result;
      r_byte_en    <= w_byte_en;
      r_misaligned <= w_misaligned;
    end else if (bus.out_ready) begin
      r_valid      <= 1'b0;
    end
  end

  // Clear takes priority, but a misaligned accept in the same cycle still counts as the first event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (err_clr) begin
      r_err_count <= (w_accept && w_misaligned) ? CNT_W'(1) : '0;
    end else if (w_accept && w_misaligned && (r_err_count != '1)) begin
      r_err_count <= r_err_count + CNT_W'(1);
    end
  end

  assign bus.out_valid      = r_valid;
  assign bus.out_data       = r_data;
  assign bus.out_byte_en    = r_byte_en;
  assign bus.out_misaligned = r_misaligned;
  assign err_count          = r_err_count;
endmodule

// File: tb/tb_mem_access_aligner.sv
// Bench for mem_access_aligner: a 32-bit build with a 2-bit counter and a 64-bit build,
// each shadowed by an arithmetic reference model, plus hand-computed directed expectations.
module tb_mem_access_aligner;
  logic clk;
  logic rst_n;
  logic err_clr_a;
  logic err_clr_b;
  logic [1:0] err_count_a;
  logic [7:0] err_count_b;

  int n_vec;
  int n_err;

  mem_access_aligner_if #(.DATA_W(32)) ifa ();
  mem_access_aligner_if #(.DATA_W(64)) ifb ();

  mem_access_aligner #(.DATA_W(32), .CNT_W(2)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .err_clr(err_clr_a), .err_count(err_count_a)
  );

  mem_access_aligner #(.DATA_W(64), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .err_clr(err_clr_b), .err_count(err_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result from the access rules, using plain 64-bit arithmetic.
  function automatic void ref_result(input int nb, input logic st, input logic [1:0] size,
                                     input logic uns, input int off,
                                     input logic [63:0] wd, input logic [63:0] rd,
                                     output logic [63:0] d, output logic [7:0] be,
                                     output logic mis);
    int sz;
    logic [63:0] mask;
    logic [63:0] field;
    sz   = 1 << size;
    mis  = (sz > nb) || ((off % sz) != 0);
    d    = '0;
    be   = '0;
    mask = (sz == 8) ? '1 : ((64'd1 << (8 * sz)) - 64'd1);
    if (!mis) begin
      be = 8'(((1 << sz) - 1) << off);
      if (st) begin
        d = (wd & mask) << (8 * off);
      end else if (sz == nb) begin
        d = rd;
      end else begin
        field = (rd >> (8 * off)) & mask;
        if (!uns && field[8*sz-1]) field = field | ~mask;
        d = field;
      end
    end
    if (nb == 4) d = d & 64'hFFFF_FFFF;
  endfunction

  // Model of the 32-bit instance
  logic [63:0] e_data_a, m_data_a;
  logic [7:0]  e_be_a, m_be_a;
  logic        e_mis_a, m_mis_a, m_valid_a;
  logic [1:0]  m_cnt_a;
  logic        m_rdy_a;

  always_comb begin
    ref_result(4, ifa.in_is_store, ifa.in_size, ifa.in_unsigned, int'(ifa.in_offset),
               64'(ifa.in_wdata), 64'(ifa.in_rdata), e_data_a, e_be_a, e_mis_a);
  end
  assign m_rdy_a = !m_valid_a || ifa.out_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_a <= 1'b0; m_data_a <= '0; m_be_a <= '0; m_mis_a <= 1'b0; m_cnt_a <= '0;
    end else begin
      if (ifa.in_valid && m_rdy_a) begin
        m_valid_a <= 1'b1; m_data_a <= e_data_a; m_be_a <= e_be_a; m_mis_a <= e_mis_a;
      end else if (ifa.out_ready) begin
        m_valid_a <= 1'b0;
      end
      if (err_clr_a) m_cnt_a <= (ifa.in_valid && m_rdy_a && e_mis_a) ? 2'd1 : 2'd0;
      else if (ifa.in_valid && m_rdy_a && e_mis_a && m_cnt_a != 2'd3) m_cnt_a <= m_cnt_a + 2'd1;
    end
  end

  // Model of the 64-bit instance
  logic [63:0] e_data_b, m_data_b;
  logic [7:0]  e_be_b, m_be_b;
  logic        e_mis_b, m_mis_b, m_valid_b;
  logic [7:0]  m_cnt_b;
  logic        m_rdy_b;

  always_comb begin
    ref_result(8, ifb.in_is_store, ifb.in_size, ifb.in_unsigned, int'(ifb.in_offset),
               ifb.in_wdata, ifb.in_rdata, e_data_b, e_be_b, e_mis_b);
  end
  assign m_rdy_b = !m_valid_b || ifb.out_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_b <= 1'b0; m_data_b <= '0; m_be_b <= '0; m_mis_b <= 1'b0; m_cnt_b <= '0;
    end else begin
      if (ifb.in_valid && m_rdy_b) begin
        m_valid_b <= 1'b1; m_data_b <= e_data_b; m_be_b <= e_be_b; m_mis_b <= e_mis_b;
      end else if (ifb.out_ready) begin
        m_valid_b <= 1'b0;
      end
      if (err_clr_b) m_cnt_b <= (ifb.in_valid && m_rdy_b && e_mis_b) ? 8'd1 : 8'd0;
      else if (ifb.in_valid && m_rdy_b && e_mis_b && m_cnt_b != 8'hFF) m_cnt_b <= m_cnt_b + 8'd1;
    end
  end

  // Cycle-by-cycle comparison against the models
  always @(negedge clk) begin
    if (rst_n) begin
      check("a_valid", 64'(ifa.out_valid), 64'(m_valid_a));
      check("a_in_ready", 64'(ifa.in_ready), 64'(m_rdy_a));
      check("a_err_count", 64'(err_count_a), 64'(m_cnt_a));
      if (m_valid_a) begin
        check("a_data", 64'(ifa.out_data), m_data_a);
        check("a_byte_en", 64'(ifa.out_byte_en), 64'(m_be_a));
        check("a_misaligned", 64'(ifa.out_misaligned), 64'(m_mis_a));
      end
      check("b_valid", 64'(ifb.out_valid), 64'(m_valid_b));
      check("b_in_ready", 64'(ifb.in_ready), 64'(m_rdy_b));
      check("b_err_count", 64'(err_count_b), 64'(m_cnt_b));
      if (m_valid_b) begin
        check("b_data", ifb.out_data, m_data_b);
        check("b_byte_en", 64'(ifb.out_byte_en), 64'(m_be_b));
        check("b_misaligned", 64'(ifb.out_misaligned), 64'(m_mis_b));
      end
    end
  end

  task automatic drive_a(input logic st, input logic [1:0] size, input logic uns,
                         input logic [1:0] off, input logic [31:0] wd, input logic [31:0] rd);
    ifa.in_is_store = st; ifa.in_size = size; ifa.in_unsigned = uns;
    ifa.in_offset = off; ifa.in_wdata = wd; ifa.in_rdata = rd; ifa.in_valid = 1'b1;
  endtask

  task automatic send_a(input logic st, input logic [1:0] size, input logic uns,
                        input logic [1:0] off, input logic [31:0] wd, input logic [31:0] rd);
    drive_a(st, size, uns, off, wd, rd);
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
  endtask

  task automatic exp_a(input string name, input logic [31:0] d, input logic [3:0] be,
                       input logic mis, input logic [1:0] cnt);
    @(negedge clk);
    check({name, "_valid"}, 64'(ifa.out_valid), 64'd1);
    check({name, "_data"}, 64'(ifa.out_data), 64'(d));
    check({name, "_be"}, 64'(ifa.out_byte_en), 64'(be));
    check({name, "_mis"}, 64'(ifa.out_misaligned), 64'(mis));
    check({name, "_cnt"}, 64'(err_count_a), 64'(cnt));
  endtask

  task automatic send_b(input logic st, input logic [1:0] size, input logic uns,
                        input logic [2:0] off, input logic [63:0] wd, input logic [63:0] rd);
    ifb.in_is_store = st; ifb.in_size = size; ifb.in_unsigned = uns;
    ifb.in_offset = off; ifb.in_wdata = wd; ifb.in_rdata = rd; ifb.in_valid = 1'b1;
    @(posedge clk); #1;
    ifb.in_valid = 1'b0;
  endtask

  task automatic exp_b(input string name, input logic [63:0] d, input logic [7:0] be,
                       input logic mis, input logic [7:0] cnt);
    @(negedge clk);
    check({name, "_valid"}, 64'(ifb.out_valid), 64'd1);
    check({name, "_data"}, ifb.out_data, d);
    check({name, "_be"}, 64'(ifb.out_byte_en), 64'(be));
    check({name, "_mis"}, 64'(ifb.out_misaligned), 64'(mis));
    check({name, "_cnt"}, 64'(err_count_b), 64'(cnt));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    err_clr_a = 1'b0;
    err_clr_b = 1'b0;
    drive_a(1'b0, 2'b00, 1'b0, 2'd0, '0, '0);
    ifa.in_valid = 1'b0;
    ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_is_store = 1'b0; ifb.in_size = 2'b00; ifb.in_unsigned = 1'b0;
    ifb.in_offset = '0; ifb.in_wdata = '0; ifb.in_rdata = '0;
    ifb.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_a_valid", 64'(ifa.out_valid), 64'd0);
    check("rst_a_data", 64'(ifa.out_data), 64'd0);
    check("rst_a_be", 64'(ifa.out_byte_en), 64'd0);
    check("rst_a_mis", 64'(ifa.out_misaligned), 64'd0);
    check("rst_a_cnt", 64'(err_count_a), 64'd0);
    check("rst_a_ready", 64'(ifa.in_ready), 64'd1);
    check("rst_b_valid", 64'(ifb.out_valid), 64'd0);
    check("rst_b_cnt", 64'(err_count_b), 64'd0);

    // Aligned loads and stores, 32-bit
    send_a(1'b0, 2'b00, 1'b0, 2'd3, 32'h0, 32'h80FF_FF12);
    exp_a("ld_b_s", 32'hFFFF_FF80, 4'b1000, 1'b0, 2'd0);
    send_a(1'b0, 2'b01, 1'b1, 2'd2, 32'h0, 32'h9ABC_1234);
    exp_a("ld_h_u", 32'h0000_9ABC, 4'b1100, 1'b0, 2'd0);
    send_a(1'b0, 2'b01, 1'b0, 2'd2, 32'h0, 32'h9ABC_1234);
    exp_a("ld_h_s", 32'hFFFF_9ABC, 4'b1100, 1'b0, 2'd0);
    send_a(1'b1, 2'b00, 1'b0, 2'd1, 32'hDEAD_BEEF, 32'h0);
    exp_a("st_b", 32'h0000_EF00, 4'b0010, 1'b0, 2'd0);
    send_a(1'b1, 2'b10, 1'b1, 2'd0, 32'hDEAD_BEEF, 32'h0);
    exp_a("st_w", 32'hDEAD_BEEF, 4'b1111, 1'b0, 2'd0);
    send_a(1'b0, 2'b10, 1'b1, 2'd0, 32'h0, 32'h8765_4321);
    exp_a("ld_w_u", 32'h8765_4321, 4'b1111, 1'b0, 2'd0);
    send_a(1'b0, 2'b00, 1'b1, 2'd2, 32'h0, 32'h0090_0000);
    exp_a("ld_b_u", 32'h0000_0090, 4'b0100, 1'b0, 2'd0);
    send_a(1'b1, 2'b01, 1'b0, 2'd2, 32'h1234_5678, 32'h0);
    exp_a("st_h", 32'h5678_0000, 4'b1100, 1'b0, 2'd0);

    // Backpressure: drain, then stall two requests
    @(posedge clk); #1;
    ifa.out_ready = 1'b0;
    drive_a(1'b0, 2'b00, 1'b1, 2'd0, 32'h0, 32'h1122_3344);
    @(posedge clk); #1;
    drive_a(1'b1, 2'b01, 1'b0, 2'd2, 32'h0000_5566, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_data", 64'(ifa.out_data), 64'h44);
      check("bp_hold_be", 64'(ifa.out_byte_en), 64'b0001);
      check("bp_in_ready", 64'(ifa.in_ready), 64'd0);
    end
    ifa.out_ready = 1'b1;
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    exp_a("bp_second", 32'h5566_0000, 4'b1100, 1'b0, 2'd0);
    @(negedge clk);
    check("bp_drained", 64'(ifa.out_valid), 64'd0);

    // Misaligned accesses and the saturating counter
    send_a(1'b0, 2'b01, 1'b0, 2'd1, 32'h0, 32'hFFFF_FFFF);
    exp_a("mis_h1", 32'h0, 4'b0000, 1'b1, 2'd1);
    send_a(1'b1, 2'b10, 1'b0, 2'd2, 32'hDEAD_BEEF, 32'h0);
    exp_a("mis_w2", 32'h0, 4'b0000, 1'b1, 2'd2);
    send_a(1'b0, 2'b11, 1'b0, 2'd0, 32'h0, 32'hFFFF_FFFF);
    exp_a("mis_d", 32'h0, 4'b0000, 1'b1, 2'd3);
    send_a(1'b0, 2'b01, 1'b1, 2'd3, 32'h0, 32'hFFFF_FFFF);
    exp_a("mis_sat", 32'h0, 4'b0000, 1'b1, 2'd3);
    err_clr_a = 1'b1;
    send_a(1'b1, 2'b01, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0);
    err_clr_a = 1'b0;
    exp_a("clr_mis", 32'h0, 4'b0000, 1'b1, 2'd1);
    err_clr_a = 1'b1;
    @(posedge clk); #1;
    err_clr_a = 1'b0;
    @(negedge clk);
    check("clr_only", 64'(err_count_a), 64'd0);

    // 64-bit build
    send_b(1'b0, 2'b11, 1'b0, 3'd0, 64'h0, 64'h0123_4567_89AB_CDEF);
    exp_b("b_ld_d", 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, 8'd0);
    send_b(1'b0, 2'b10, 1'b0, 3'd4, 64'h0, 64'h8000_0001_1234_5678);
    exp_b("b_ld_w_s", 64'hFFFF_FFFF_8000_0001, 8'hF0, 1'b0, 8'd0);
    send_b(1'b1, 2'b01, 1'b0, 3'd6, 64'h1111_2222_3333_BEEF, 64'h0);
    exp_b("b_st_h", 64'hBEEF_0000_0000_0000, 8'hC0, 1'b0, 8'd0);
    send_b(1'b0, 2'b00, 1'b1, 3'd5, 64'h0, 64'h0000_A500_0000_0000);
    exp_b("b_ld_b_u", 64'h0000_0000_0000_00A5, 8'h20, 1'b0, 8'd0);
    send_b(1'b1, 2'b11, 1'b0, 3'd0, 64'hCAFE_F00D_1234_5678, 64'h0);
    exp_b("b_st_d", 64'hCAFE_F00D_1234_5678, 8'hFF, 1'b0, 8'd0);
    ifb.out_ready = 1'b0;
    @(posedge clk); #1;
    ifb.out_ready = 1'b1;
    @(posedge clk); #1;
    ifb.out_ready = 1'b0;
    send_b(1'b0, 2'b10, 1'b0, 3'd2, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    exp_b("b_mis_w2", 64'h0, 8'h00, 1'b1, 8'd1);

    // Asynchronous reset while a result is pending
    #2 rst_n = 1'b0;
    #1;
    check("arst_b_valid", 64'(ifb.out_valid), 64'd0);
    check("arst_b_cnt", 64'(err_count_b), 64'd0);
    check("arst_b_mis", 64'(ifb.out_misaligned), 64'd0);
    check("arst_a_cnt", 64'(err_count_a), 64'd0);
    ifb.out_ready = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
